// File: rtl/qnr_div_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined divider among N_REQ requesters.
// Each issue carries its requester id down a tag pipe so quotients route back in issue order.
module qnr_div_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DIVD_W  = 24,
  parameter int unsigned DIVS_W  = 12,
  parameter int unsigned LATENCY = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*DIVD_W-1:0]      req_dividend,
  input  logic [N_REQ*DIVS_W-1:0]      req_divisor,
  output logic                         div_in_valid,
  output logic [DIVD_W-1:0]            div_z,
  output logic [DIVS_W-1:0]            div_d,
  input  logic [DIVD_W-1:0]            div_q,
  input  logic                         div_ovf,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [DIVD_W-1:0]            rsp_q,
  output logic                         rsp_ovf,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         busy,
  output logic [$clog2(LATENCY+3)-1:0] inflight
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY + 3);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] iss_id;
  logic            grant_found;
  logic            run_c;
  logic            hs_c;
  int unsigned     idx;
  logic            tag_v  [LATENCY];
  logic [ID_W-1:0] tag_id [LATENCY];

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Grants only while running; a drain waits for every issued op to respond
  always_comb begin
    state_d   = state_q;
    run_c     = 1'b0;
    req_ready = '0;
    unique case (state_q)
      S_RUN: begin
        run_c = 1'b1;
        if (flush_req) state_d = S_DRAIN;
      end
      S_DRAIN: if (inflight == '0) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    hs_c = run_c & grant_found;
    if (hs_c) req_ready = N_REQ'(1) << grant_id;
  end

  assign flush_done = (state_q == S_DONE);
  assign busy       = (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      div_in_valid <= 1'b0;
      div_z        <= '0;
      div_d        <= '0;
      iss_id       <= '0;
      rsp_valid    <= '0;
      rsp_q        <= '0;
      rsp_ovf      <= 1'b0;
      inflight     <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      div_in_valid <= hs_c;
      if (hs_c) begin
        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        div_z  <= req_dividend[32'(grant_id) * DIVD_W +: DIVD_W];
        div_d  <= req_divisor[32'(grant_id) * DIVS_W +: DIVS_W];
        iss_id <= grant_id;
      end

      // Tag pipe lines up with the divider so the last stage marks div_q as ours
      tag_v[0]  <= div_in_valid;
      tag_id[0] <= iss_id;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      rsp_valid <= tag_v[LATENCY-1] ? (N_REQ'(1) << tag_id[LATENCY-1]) : '0;
      rsp_ovf   <= tag_v[LATENCY-1] & div_ovf;
      if (tag_v[LATENCY-1]) rsp_q <= div_q;

      case ({hs_c, (rsp_valid != '0)})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_qnr_div_scheduler.sv
// Bench for qnr_div_scheduler: behavioural divider plus a cycle-indexed scoreboard that
// predicts grants, responses, inflight count and flush timing from the arbitration rules.
module tb_qnr_div_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 24;
  localparam int unsigned SW = 12;
  localparam int unsigned L  = 12;
  localparam int unsigned CW = $clog2(L + 3);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_dividend;
  logic [N*SW-1:0] req_divisor;
  logic            div_in_valid, div_ovf, rsp_ovf, flush_req, flush_done, busy;
  logic [DW-1:0]   div_z, div_q, rsp_q;
  logic [SW-1:0]   div_d;
  logic [CW-1:0]   inflight;

  always #5 clk = ~clk;

  qnr_div_scheduler #(.N_REQ(N), .DIVD_W(DW), .DIVS_W(SW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .div_in_valid(div_in_valid),
    .div_z(div_z), .div_d(div_d), .div_q(div_q), .div_ovf(div_ovf), .rsp_valid(rsp_valid),
    .rsp_q(rsp_q), .rsp_ovf(rsp_ovf), .flush_req(flush_req), .flush_done(flush_done),
    .busy(busy), .inflight(inflight)
  );

  // Behavioural divider: quotient appears L cycles after the operand cycle
  logic [DW-1:0] dq_pipe   [L];
  logic          dovf_pipe [L];
  always @(posedge clk) begin
    dq_pipe[0]   <= (div_d == '0) ? {DW{1'b1}} : div_z / DW'(div_d);
    dovf_pipe[0] <= (div_d == '0);
    for (int k = 1; k < L; k++) begin
      dq_pipe[k]   <= dq_pipe[k-1];
      dovf_pipe[k] <= dovf_pipe[k-1];
    end
  end
  assign div_q   = dq_pipe[L-1];
  assign div_ovf = dovf_pipe[L-1];

  typedef struct {
    int            id;
    logic [DW-1:0] q;
    logic          ovf;
    int            t;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] op_z [N];
  logic [SW-1:0] op_d [N];
  int            cyc, m_rr, m_st, n_checks, n_fail;
  logic          prev_hs;
  logic [DW-1:0] prev_z;
  logic [SW-1:0] prev_d;

  logic [N-1:0]  obs_ready, obs_rsp_valid, exp_ready, exp_rsp_valid;
  logic [DW-1:0] obs_rsp_q, exp_rsp_q, obs_div_z, exp_div_z;
  logic [SW-1:0] obs_div_d, exp_div_d;
  logic          obs_rsp_ovf, exp_rsp_ovf, obs_div_v, exp_div_v, obs_done, exp_done, obs_busy;
  logic [CW-1:0] obs_inflight;
  int            exp_inflight;

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; flush_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_rr = 0; m_st = 0; prev_hs = 1'b0; prev_z = '0; prev_d = '0;
    cyc++;
  endtask

  // One clock: drive inputs, sample at negedge, compute expectations, advance the model
  task automatic step(input logic [N-1:0] v, input logic fl);
    int g;
    logic [DW-1:0] qv;
    req_valid = v; flush_req = fl;
    for (int i = 0; i < N; i++) begin
      req_dividend[i*DW +: DW] = op_z[i];
      req_divisor[i*SW +: SW]  = op_d[i];
    end
    @(negedge clk);
    obs_ready = req_ready; obs_rsp_valid = rsp_valid; obs_rsp_q = rsp_q; obs_rsp_ovf = rsp_ovf;
    obs_div_v = div_in_valid; obs_div_z = div_z; obs_div_d = div_d; obs_done = flush_done;
    obs_busy = busy; obs_inflight = inflight;

    g = -1;
    if (m_st == 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    exp_rsp_valid = '0; exp_rsp_q = '0; exp_rsp_ovf = 1'b0; exp_inflight = 0;
    foreach (sb[j]) begin
      if (sb[j].t < cyc && cyc <= sb[j].t + L + 2) exp_inflight++;
      if (sb[j].t + L + 2 == cyc) begin
        exp_rsp_valid[sb[j].id] = 1'b1; exp_rsp_q = sb[j].q; exp_rsp_ovf = sb[j].ovf;
      end
    end
    while (sb.size() > 0 && sb[0].t + L + 2 <= cyc) void'(sb.pop_front());
    exp_div_v = prev_hs; exp_div_z = prev_z; exp_div_d = prev_d;
    exp_done = (m_st == 2);

    prev_hs = (g >= 0);
    if (g >= 0) begin
      prev_z = op_z[g]; prev_d = op_d[g];
      qv = (op_d[g] == '0) ? {DW{1'b1}} : op_z[g] / DW'(op_d[g]);
      sb.push_back('{id: g, q: qv, ovf: (op_d[g] == '0), t: cyc});
      m_rr = (g + 1) % N;
    end
    case (m_st)
      0: if (fl) m_st = 1;
      1: if (exp_inflight == 0) m_st = 2;
      default: m_st = 0;
    endcase
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    step('0, 1'b0);
    n_checks++; if (obs_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
    n_checks++; if (obs_rsp_valid !== '0 || obs_rsp_q !== '0 || obs_rsp_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp got v=%b q=%0d o=%b exp 0", obs_rsp_valid, obs_rsp_q, obs_rsp_ovf); end
    n_checks++; if (obs_div_v !== 1'b0 || obs_div_z !== '0 || obs_div_d !== '0) begin
      n_fail++; $display("FAIL reset_div got v=%b z=%0d d=%0d exp 0", obs_div_v, obs_div_z, obs_div_d); end
    n_checks++; if (obs_inflight !== '0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got inflight=%0d busy=%b done=%b exp 0", obs_inflight, obs_busy, obs_done); end
  endtask

  task automatic test_single();
    op_z[2] = DW'(1000); op_d[2] = SW'(7);
    step(4'b0100, 1'b0);
    n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", obs_ready); end
    for (int n = 1; n <= L + 4; n++) begin
      step('0, 1'b0);
      if (n == 1) begin
        n_checks++; if (obs_div_v !== 1'b1 || obs_div_z !== DW'(1000) || obs_div_d !== SW'(7)) begin
          n_fail++; $display("FAIL single_issue got v=%b z=%0d d=%0d exp 1/1000/7", obs_div_v, obs_div_z, obs_div_d); end
      end
      if (n == L + 2) begin
        n_checks++; if (obs_rsp_valid !== 4'b0100 || obs_rsp_q !== DW'(142)) begin
          n_fail++; $display("FAIL single_rsp got v=%b q=%0d exp 0100/142", obs_rsp_valid, obs_rsp_q); end
      end else begin
        n_checks++; if (obs_rsp_valid !== '0) begin n_fail++; $display("FAIL single_quiet n=%0d got=%b exp=0", n, obs_rsp_valid); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int n = 0; n < 16 + L + 4; n++) begin
      for (int i = 0; i < N; i++) begin op_z[i] = DW'($urandom); op_d[i] = SW'($urandom_range(1, 4095)); end
      step((n < 16) ? {N{1'b1}} : '0, 1'b0);
      if (n < 16) begin
        n_checks++; if (obs_ready !== (N'(1) << (n % N))) begin
          n_fail++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, obs_ready, N'(1) << (n % N)); end
      end
      n_checks++; if (obs_rsp_valid !== exp_rsp_valid) begin
        n_fail++; $display("FAIL rr_rsp n=%0d got=%b exp=%b", n, obs_rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        n_checks++; if (obs_rsp_q !== exp_rsp_q) begin n_fail++; $display("FAIL rr_q n=%0d got=%0d exp=%0d", n, obs_rsp_q, exp_rsp_q); end
      end
    end
  endtask

  task automatic test_streaming();
    int mx;
    mx = 0;
    for (int n = 0; n < 20 + L + 6; n++) begin
      for (int i = 0; i < N; i++) begin op_z[i] = DW'($urandom); op_d[i] = SW'($urandom_range(1, 4095)); end
      step((n < 20) ? (N'(1) << $urandom_range(0, N - 1)) : '0, 1'b0);
      if (int'(obs_inflight) > mx) mx = int'(obs_inflight);
      n_checks++; if (obs_inflight !== CW'(exp_inflight) || obs_busy !== (exp_inflight != 0)) begin
        n_fail++; $display("FAIL stream_inflight n=%0d got=%0d busy=%b exp=%0d", n, obs_inflight, obs_busy, exp_inflight); end
    end
    n_checks++; if (mx != L + 2) begin n_fail++; $display("FAIL stream_peak got=%0d exp=%0d", mx, L + 2); end
  endtask

  task automatic test_div_zero();
    op_z[1] = DW'(12345); op_d[1] = '0;
    step(4'b0010, 1'b0);
    for (int n = 1; n <= L + 4; n++) begin
      step('0, 1'b0);
      n_checks++; if (obs_rsp_ovf !== (n == L + 2)) begin
        n_fail++; $display("FAIL dz_ovf n=%0d got=%b exp=%b", n, obs_rsp_ovf, n == L + 2); end
      if (n == L + 2) begin
        n_checks++; if (obs_rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL dz_rsp got=%b exp=0010", obs_rsp_valid); end
      end
    end
  endtask

  task automatic test_flush();
    int last_rsp, done_cyc, c0, f0;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N; i++) begin op_z[i] = DW'($urandom); op_d[i] = SW'($urandom_range(1, 4095)); end
      step(N'(1) << $urandom_range(0, N - 1), 1'b0);
    end
    step('0, 1'b1);
    last_rsp = -1; done_cyc = -1;
    for (int n = 0; n < 40 && done_cyc < 0; n++) begin
      c0 = cyc;
      step({N{1'b1}}, 1'b0);
      n_checks++; if (obs_ready !== '0) begin n_fail++; $display("FAIL flush_ready n=%0d got=%b exp=0", n, obs_ready); end
      n_checks++; if (obs_done !== exp_done) begin n_fail++; $display("FAIL flush_done_seq n=%0d got=%b exp=%b", n, obs_done, exp_done); end
      if (obs_rsp_valid != '0) last_rsp = c0;
      if (obs_done) done_cyc = c0;
    end
    n_checks++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL flush_timeout got=none exp=flush_done within 40 cycles"); end
    else if (done_cyc - last_rsp != 2) begin
      n_fail++; $display("FAIL flush_gap got=%0d exp=2 cycles after last rsp", done_cyc - last_rsp); end
    for (int n = 0; n < L + 4; n++) step('0, 1'b0);
    f0 = cyc;
    step('0, 1'b1);
    for (int n = 1; n <= 3; n++) begin
      step('0, 1'b0);
      n_checks++; if (obs_done !== (cyc - 1 - f0 == 2)) begin
        n_fail++; $display("FAIL flush_idle n=%0d got=%b exp=%b", n, obs_done, cyc - 1 - f0 == 2); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300 + L + 4; n++) begin
      for (int i = 0; i < N; i++) begin
        op_z[i] = DW'($urandom);
        op_d[i] = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
      end
      step((n < 300) ? N'($urandom) : '0, (n < 300) && ($urandom_range(0, 39) == 0));
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, obs_ready, exp_ready); end
      n_checks++; if (obs_rsp_valid !== exp_rsp_valid || obs_rsp_ovf !== exp_rsp_ovf) begin
        n_fail++; $display("FAIL rand_rsp n=%0d got=%b/%b exp=%b/%b", n, obs_rsp_valid, obs_rsp_ovf, exp_rsp_valid, exp_rsp_ovf); end
      if (exp_rsp_valid != '0) begin
        n_checks++; if (obs_rsp_q !== exp_rsp_q) begin n_fail++; $display("FAIL rand_q n=%0d got=%0d exp=%0d", n, obs_rsp_q, exp_rsp_q); end
      end
      n_checks++; if (obs_div_v !== exp_div_v) begin n_fail++; $display("FAIL rand_issue n=%0d got=%b exp=%b", n, obs_div_v, exp_div_v); end
      if (exp_div_v) begin
        n_checks++; if (obs_div_z !== exp_div_z || obs_div_d !== exp_div_d) begin
          n_fail++; $display("FAIL rand_operand n=%0d got=%0d/%0d exp=%0d/%0d", n, obs_div_z, obs_div_d, exp_div_z, exp_div_d); end
      end
      n_checks++; if (obs_inflight !== CW'(exp_inflight) || obs_done !== exp_done) begin
        n_fail++; $display("FAIL rand_status n=%0d got=%0d/%b exp=%0d/%b", n, obs_inflight, obs_done, exp_inflight, exp_done); end
    end
  endtask

  task automatic test_reset_midop();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) begin op_z[i] = DW'($urandom); op_d[i] = SW'($urandom_range(1, 4095)); end
      step(N'(1) << $urandom_range(1, N - 1), 1'b0);
    end
    do_reset();
    for (int n = 0; n < L + 4; n++) begin
      step('0, 1'b0);
      n_checks++; if (obs_rsp_valid !== '0 || obs_inflight !== '0) begin
        n_fail++; $display("FAIL midrst_quiet n=%0d got v=%b inflight=%0d exp 0", n, obs_rsp_valid, obs_inflight); end
    end
    step({N{1'b1}}, 1'b0);
    n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_grant got=%b exp=0001", obs_ready); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; req_valid = '0; flush_req = 1'b0; req_dividend = '0; req_divisor = '0;
    for (int i = 0; i < N; i++) begin op_z[i] = '0; op_d[i] = SW'(1); end
    do_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_streaming();
    test_div_zero();
    test_flush();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
